// File: rtl/piso_stream_tx.sv
// piso_stream_tx: valid/ready parallel-in serial-out transmitter with a one-word holding buffer
module piso_stream_tx #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             so,
  output logic             so_valid,
  output logic             so_last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [WIDTH-1:0] shreg, hold_data;
  logic [CW-1:0] bitcnt;
  logic hold_full, active, at_last, load_now, accept;
  // Load/handshake decode; the buffer may be refilled on the same edge it empties into the shifter
  always_comb begin
    at_last  = active && (bitcnt == LAST);
    load_now = hold_full && (!active || at_last);
    in_ready = rst_n && (!hold_full || load_now);
    accept   = in_valid && in_ready;
    so       = active && (LSB_FIRST ? shreg[0] : shreg[WIDTH-1]);
    so_valid = active;
    so_last  = at_last;
    busy     = active || hold_full;
  end
  // Holding buffer: captures every accepted word, drains into the shifter on load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else begin
      if (accept) hold_data <= in_data;
      hold_full <= accept ? 1'b1 : (load_now ? 1'b0 : hold_full);
    end
  end
  // Shifter: loads from the buffer, shifts toward the output end, idles when nothing follows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      bitcnt <= '0;
      active <= 1'b0;
    end else if (load_now) begin
      shreg  <= hold_data;
      bitcnt <= '0;
      active <= 1'b1;
    end else if (active) begin
      if (!at_last) begin
        shreg  <= LSB_FIRST ? {1'b0, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], 1'b0};
        bitcnt <= bitcnt + 1'b1;
      end else begin
        shreg  <= '0;
        bitcnt <= '0;
        active <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_piso_stream_tx.sv
// tb_piso_stream_tx: scoreboard bench for piso_stream_tx (LSB-first and MSB-first instances)
module tb_piso_stream_tx;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [3:0] in_data = '0, m_in_data = '0;
  logic in_valid = 1'b0, m_in_valid = 1'b0;
  logic in_ready, so, so_valid, so_last, busy;
  logic m_in_ready, m_so, m_so_valid, m_so_last, m_busy;
  logic [1:0] q[$];
  logic [1:0] e;
  logic [3:0] sipo = '0;
  int vec = 0, errs = 0, lasts = 0;

  piso_stream_tx #(.WIDTH(4), .LSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .so(so), .so_valid(so_valid), .so_last(so_last), .busy(busy));
  piso_stream_tx #(.WIDTH(4), .LSB_FIRST(0)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_data(m_in_data), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .so(m_so), .so_valid(m_so_valid), .so_last(m_so_last), .busy(m_busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send(input logic [3:0] w, input int gap);
    int n = 0;
    in_data = w;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    else for (int i = 0; i < 4; i++) q.push_back({1'(i == 3), w[i]});
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  always @(posedge clk) if (so_valid) sipo <= {so, sipo[3:1]};

  always @(negedge clk) if (rst_n && so_valid) begin
    if (q.size() == 0) chk("extra_bit", 1, 0);
    else begin
      e = q.pop_front();
      chk("so", so, e[0]);
      chk("so_last", so_last, e[1]);
    end
    if (so_last) lasts++;
  end

  initial begin
    int n, cnt, run, maxrun, l0;
    logic [3:0] got, lastv;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_outputs", {so, so_valid, so_last, busy}, 0);
    chk("rst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_outputs", {so, so_valid, so_last, busy}, 0);
    @(negedge clk);
    send(4'b1011, 0);
    chk("lat_idle", so_valid, 0);
    chk("lat_busy", busy, 1);
    @(negedge clk);
    chk("lat_first", so_valid, 1);
    repeat (4) @(negedge clk);
    chk("single_done", so_valid, 0);
    chk("sipo_word", sipo, 4'b1011);
    @(negedge clk);
    send(4'hA, 0);
    send(4'h5, 0);
    chk("b2b_stall", in_ready, 0);
    cnt = 0; run = 0; maxrun = 0;
    for (int i = 0; i < 12; i++) begin
      if (so_valid) begin cnt++; run++; end else run = 0;
      if (run > maxrun) maxrun = run;
      @(negedge clk);
    end
    chk("b2b_count", cnt, 8);
    chk("b2b_contig", maxrun, 8);
    m_in_data = 4'b1000;
    m_in_valid = 1'b1;
    n = 0;
    while (!m_in_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    m_in_valid = 1'b0;
    n = 0;
    while (!m_so_valid && n < 10) begin @(negedge clk); n++; end
    for (int i = 0; i < 4; i++) begin
      got[3-i] = m_so;
      lastv[i] = m_so_last;
      @(negedge clk);
    end
    chk("msb_word", got, 4'b1000);
    chk("msb_last", lastv, 4'b1000);
    chk("msb_idle", {m_so_valid, m_busy}, 0);
    send(4'hF, 0);
    send(4'h3, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_valid", so_valid, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (so_valid || busy) cnt++;
      @(negedge clk);
    end
    chk("post_rst_quiet", cnt, 0);
    l0 = lasts;
    for (int i = 0; i < 50; i++) send(4'($urandom_range(0, 15)), $urandom_range(0, 3));
    n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    chk("drain_queue", q.size(), 0);
    chk("last_pulses", lasts - l0, 50);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/piso_stream_tx.md
Name: piso_stream_tx

Overview:
- Parallel-in, serial-out transmitter with a valid/ready word interface and a one-word holding buffer.
- Feeds a serial shift stage such as a SIPO deserializer or SISO delay line.
- Default settings send LSB first, so a 4-bit SIPO that shifts in at bit 3 holds the original word after the last bit.
- Back-to-back words stream with no idle cycles between them.

Parameters:
- WIDTH, 4, word width in bits; must be 2 or more.
- LSB_FIRST, 1, 1 = bit 0 is sent first; 0 = bit WIDTH-1 is sent first.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  parallel word from the producer.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block can accept a word this cycle.
- so  output  1  serial data bit.
- so_valid  output  1  so carries a valid bit this cycle.
- so_last  output  1  so carries the final bit of the current word.
- busy  output  1  shifter is active or the holding buffer is full.

Behaviour:
- Reset, asynchronous on rst_n low:
  - shreg, bitcnt, hold_data, hold_full and active all clear to 0.
  - so, so_valid, so_last and busy read 0.
  - in_ready is forced to 0 while rst_n is low and reads 1 in the first cycle after release.
- Handshake:
  - A word is accepted on a rising edge where in_valid and in_ready are both 1.
  - Every accepted word is written into hold_data and hold_full is set.
  - The producer holds in_data stable while in_valid=1 and in_ready=0; the block never drops or duplicates a word.
- Load condition, load_now = hold_full and (active=0, or active=1 with bitcnt=WIDTH-1).
- in_ready = not hold_full, or load_now. This allows the hold buffer to be refilled on the same edge it is emptied.
- On a load edge:
  - hold_data moves to shreg, active=1, bitcnt=0.
  - hold_full ends at 1 if a handshake also occurs on that edge, otherwise 0.
- On a shift edge (active=1 and no load):
  - If bitcnt<WIDTH-1: shreg shifts toward the output end with 0 filled in, and bitcnt increments.
  - If bitcnt=WIDTH-1 and hold is empty: active=0, shreg clears to 0, bitcnt=0.
- Outputs:
  - so = shreg[0] when LSB_FIRST=1, else shreg[WIDTH-1]. so is 0 when active=0.
  - so_valid = active.
  - so_last = active and bitcnt=WIDTH-1.
  - busy = active or hold_full.
- Latency: a word accepted at edge N presents its first bit in the cycle after edge N+1, and its last bit WIDTH-1 cycles later.
- Throughput: one bit per clock; no bubble between consecutive words when in_valid stays high.
- Boundary conditions:
  - Reset mid-word: the partial word and the held word are both discarded; no bits from them appear after release.
  - in_valid low while hold is empty and the last bit is sent: block returns to idle, with so_valid=0 in the next cycle.

Test Plan (WIDTH=4 unless stated):
- Reset check: assert rst_n=0 -> so, so_valid, so_last, busy and in_ready all 0; release -> in_ready=1 in the next cycle, other outputs stay 0.
- Single word, LSB_FIRST=1:
  - Stimulus: in_data=4'b1011 accepted at edge N.
  - Required: so_valid high for exactly 4 cycles, so=1,1,0,1, so_last only on the 4th bit.
  - Required: a downstream 4-bit SIPO clocked on so_valid cycles holds 4'b1011 afterward.
- Back-to-back words:
  - Stimulus: in_valid held high with 4'hA then 4'h5.
  - Required: 8 contiguous so_valid cycles, so=0,1,0,1,1,0,1,0, with so_last on the 4th and 8th bits.
  - Required: in_ready low while hold_full=1 and no load is pending.
- MSB first: LSB_FIRST=0 with in_data=4'b1000 -> so=1,0,0,0, then so_valid=0 and busy=0.
- Reset mid-word: rst_n pulsed low during the 2nd bit of 4'hF with 4'h3 held -> so_valid=0 immediately; after release no bits appear until a new handshake.
- Random stall check: in_valid randomized with stable in_data for 50 words -> output bit stream equals the concatenated input words in order, with exactly 50 so_last pulses.
